// File: rtl/ninjakun_inp_mp.sv
// Dual-CPU input multiplexer: synchronized control panels, VBLK edge flags and
// inter-CPU sync flags, readable by both CPUs through a 3-bit address map.
// Optional panel debounce is enabled by defining NINJAKUN_INP_DEBOUNCE_EN.
module ninjakun_inp_mp #(
    parameter int unsigned NPANEL = 2,
    parameter int unsigned NFLAG  = 2,
    parameter int unsigned DBW    = 8
) (
    input  logic                INPCL,
    input  logic                RESET_N,
    input  logic [8*NPANEL-1:0] CTRi,
    input  logic                VBLK,
    input  logic [2:0]          AD0,
    input  logic [2:0]          AD1,
    input  logic [7:0]          OD0,
    input  logic [7:0]          OD1,
    input  logic                WR0,
    input  logic                WR1,
    input  logic                RD0,
    input  logic                RD1,
    output logic [7:0]          INPD0,
    output logic [7:0]          INPD1
);

    localparam int unsigned PW       = 8 * NPANEL;
    localparam logic [2:0]  AddrFlag = 3'(NPANEL);
    localparam logic [2:0]  AddrVbe  = 3'(NPANEL + 1);

    logic [PW-1:0]    ctr_s1_q, ctr_s2_q;
    logic [PW-1:0]    deb;
    logic             vblk_s1_q, vblk_s2_q, vblk_p_q;
    logic [NFLAG-1:0] flag_q, flag_d;
    logic             vbe0_q, vbe0_d, vbe1_q, vbe1_d;
    logic             wr0_hit, wr1_hit, rd0_hit, rd1_hit, vblk_rise;
    logic [7:0]       flag_word, vbe_word;
    logic             unused_od;

    // Bits of the write data above the flag field carry no meaning.
    assign unused_od = ^{OD0[7:NFLAG], OD1[7:NFLAG]};

    // Two-flop synchronizers for the asynchronous panels and VBLK.
    always_ff @(posedge INPCL or negedge RESET_N) begin
        if (!RESET_N) begin
            ctr_s1_q  <= '1;
            ctr_s2_q  <= '1;
            vblk_s1_q <= 1'b0;
            vblk_s2_q <= 1'b0;
        end else begin
            ctr_s1_q  <= CTRi;
            ctr_s2_q  <= ctr_s1_q;
            vblk_s1_q <= VBLK;
            vblk_s2_q <= vblk_s1_q;
        end
    end

`ifdef NINJAKUN_INP_DEBOUNCE_EN
    logic [DBW-1:0] div_q;
    logic [PW-1:0]  samp_q, deb_q, deb_d, agree;
    logic           tick;

    // Tick on the cycle the divider wraps from all-ones back to zero.
    assign tick = &div_q;

    // A bit only moves when the current and previous tick samples agree.
    always_comb begin
        agree = ~(ctr_s2_q ^ samp_q);
        deb_d = (agree & ctr_s2_q) | (~agree & deb_q);
    end

    // Divider, tick sampler and debounced panel state.
    always_ff @(posedge INPCL or negedge RESET_N) begin
        if (!RESET_N) begin
            div_q  <= '0;
            samp_q <= '1;
            deb_q  <= '1;
        end else begin
            div_q <= div_q + 1'b1;
            if (tick) begin
                samp_q <= ctr_s2_q;
                deb_q  <= deb_d;
            end
        end
    end

    assign deb = deb_q;
`else
    logic [DBW-1:0] unused_dbw;

    assign unused_dbw = '0;
    assign deb        = ctr_s2_q;
`endif

    assign wr0_hit   = WR0 && (AD0 == AddrFlag);
    assign wr1_hit   = WR1 && (AD1 == AddrFlag);
    assign rd0_hit   = RD0 && (AD0 == AddrVbe);
    assign rd1_hit   = RD1 && (AD1 == AddrVbe);
    assign vblk_rise = vblk_s2_q && !vblk_p_q;

    // Flag updates: CPU1 is applied last so it wins any same-cycle conflict.
    always_comb begin
        flag_d = flag_q;
        for (int k = 0; k < NFLAG; k++) begin
            if (wr0_hit && OD0[k]) flag_d[k] = (k % 2 == 0);
            if (wr1_hit && OD1[k]) flag_d[k] = (k % 2 != 0);
        end
    end

    // VBLK edge sets both VBE bits; a read clears only its own, and set wins.
    always_comb begin
        vbe0_d = vblk_rise ? 1'b1 : (rd0_hit ? 1'b0 : vbe0_q);
        vbe1_d = vblk_rise ? 1'b1 : (rd1_hit ? 1'b0 : vbe1_q);
    end

    // Flag, VBE and VBLK edge-detect state.
    always_ff @(posedge INPCL or negedge RESET_N) begin
        if (!RESET_N) begin
            flag_q   <= '0;
            vbe0_q   <= 1'b0;
            vbe1_q   <= 1'b0;
            vblk_p_q <= 1'b0;
        end else begin
            flag_q   <= flag_d;
            vbe0_q   <= vbe0_d;
            vbe1_q   <= vbe1_d;
            vblk_p_q <= vblk_s2_q;
        end
    end

    // Status words shared by both read ports.
    always_comb begin
        flag_word             = '0;
        flag_word[NFLAG+1:2]  = flag_q;
        flag_word[1]          = ~vblk_s2_q;
        vbe_word              = {6'b0, vbe1_q, vbe0_q};
    end

    function automatic logic [7:0] rd_mux(input logic [2:0]    ad,
                                          input logic [PW-1:0] pan,
                                          input logic [7:0]    fw,
                                          input logic [7:0]    vw);
        logic [7:0] r;
        r = 8'hFF;
        for (int p = 0; p < NPANEL; p++) begin
            if (ad == 3'(p)) r = pan[8*p +: 8];
        end
        if (ad == AddrFlag) r = fw;
        if (ad == AddrVbe)  r = vw;
        return r;
    endfunction

    assign INPD0 = rd_mux(AD0, deb, flag_word, vbe_word);
    assign INPD1 = rd_mux(AD1, deb, flag_word, vbe_word);

endmodule

// File: tb/tb_ninjakun_inp_mp.sv
// Scoreboard bench for ninjakun_inp_mp (NPANEL=2, NFLAG=2, DBW=4).
// Stimulus pushes expected read data per CPU; a negedge monitor pops and
// compares whenever that CPU strobes a read.
module tb_ninjakun_inp_mp;

    localparam int NPANEL = 2;
    localparam int NFLAG  = 2;
    localparam int DBW    = 4;

    logic        INPCL = 1'b0;
    logic        RESET_N = 1'b0;
    logic [15:0] CTRi = 16'hFFFF;
    logic        VBLK = 1'b0;
    logic [2:0]  AD0 = 3'd0, AD1 = 3'd0;
    logic [7:0]  OD0 = 8'h00, OD1 = 8'h00;
    logic        WR0 = 1'b0, WR1 = 1'b0, RD0 = 1'b0, RD1 = 1'b0;
    logic [7:0]  INPD0, INPD1;

    typedef struct {
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    ninjakun_inp_mp #(
        .NPANEL(NPANEL),
        .NFLAG (NFLAG),
        .DBW   (DBW)
    ) dut (
        .INPCL  (INPCL),
        .RESET_N(RESET_N),
        .CTRi   (CTRi),
        .VBLK   (VBLK),
        .AD0    (AD0),
        .AD1    (AD1),
        .OD0    (OD0),
        .OD1    (OD1),
        .WR0    (WR0),
        .WR1    (WR1),
        .RD0    (RD0),
        .RD1    (RD1),
        .INPD0  (INPD0),
        .INPD1  (INPD1)
    );

    always #5 INPCL = ~INPCL;

    task automatic push(input int cpu, input logic [7:0] exp, input string nm);
        exp_t e;
        e.exp  = exp;
        e.name = nm;
        if (cpu == 0) q0.push_back(e);
        else          q1.push_back(e);
    endtask

    task automatic check_pop(input int cpu, input logic [7:0] act);
        exp_t e;
        n_chk++;
        if ((cpu == 0 && q0.size() == 0) || (cpu == 1 && q1.size() == 0)) begin
            $display("FAIL unexpected_read cpu%0d got %02h expected no read", cpu, act);
            return;
        end
        if (cpu == 0) e = q0.pop_front();
        else          e = q1.pop_front();
        if (act === e.exp) n_pass++;
        else $display("FAIL %s cpu%0d got %02h expected %02h", e.name, cpu, act, e.exp);
    endtask

    // Monitor: sample read data mid-cycle, away from the rising edge.
    always @(negedge INPCL) begin
        if (RESET_N) begin
            if (RD0) check_pop(0, INPD0);
            if (RD1) check_pop(1, INPD1);
        end
    end

    // One-cycle read strobe on a single CPU.
    task automatic rd(input int cpu, input logic [2:0] a, input logic [7:0] exp,
                      input string nm);
        @(posedge INPCL); #1;
        if (cpu == 0) begin AD0 = a; RD0 = 1'b1; end
        else          begin AD1 = a; RD1 = 1'b1; end
        push(cpu, exp, nm);
        @(posedge INPCL); #1;
        RD0 = 1'b0;
        RD1 = 1'b0;
    endtask

    // One-cycle write strobe(s).
    task automatic wr(input logic w0, input logic [2:0] a0, input logic [7:0] d0,
                      input logic w1, input logic [2:0] a1, input logic [7:0] d1);
        @(posedge INPCL); #1;
        WR0 = w0; AD0 = a0; OD0 = d0;
        WR1 = w1; AD1 = a1; OD1 = d1;
        @(posedge INPCL); #1;
        WR0 = 1'b0;
        WR1 = 1'b0;
    endtask

    task automatic rd_both(input logic [2:0] a, input logic [7:0] exp, input string nm);
        rd(0, a, exp, nm);
        rd(1, a, exp, nm);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog timeout got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge INPCL);
        #1 RESET_N = 1'b1;

        // Reset state through both ports.
        for (int a = 0; a < 5; a++) begin
            logic [7:0] e;
            case (a)
                2:       e = 8'h02;
                3:       e = 8'h00;
                default: e = 8'hFF;
            endcase
            rd_both(3'(a), e, "reset_read");
        end
        rd(0, 3'd7, 8'hFF, "unmapped_addr7");

`ifdef NINJAKUN_INP_DEBOUNCE_EN
        // Held low long enough for two agreeing ticks.
        @(posedge INPCL); #1;
        CTRi[0] = 1'b0;
        repeat (40) @(posedge INPCL);
        rd(0, 3'd0, 8'hFE, "debounce_settle");
        // Short high glitch must be filtered.
        @(posedge INPCL); #1;
        CTRi[0] = 1'b1;
        repeat (3) @(posedge INPCL);
        #1 CTRi[0] = 1'b0;
        rd(0, 3'd0, 8'hFE, "glitch_just_after");
        repeat (40) @(posedge INPCL);
        rd(1, 3'd0, 8'hFE, "glitch_filtered");
`else
        // Two-clock synchronizer latency with no filtering.
        @(posedge INPCL); #1;
        CTRi[0] = 1'b0; AD0 = 3'd0; RD0 = 1'b1;
        push(0, 8'hFF, "lat_cycle0");
        @(posedge INPCL); #1;
        push(0, 8'hFF, "lat_cycle1");
        @(posedge INPCL); #1;
        push(0, 8'hFE, "lat_cycle2");
        @(posedge INPCL); #1;
        CTRi[0] = 1'b1;
        push(0, 8'hFE, "glitch_c0");
        @(posedge INPCL); #1;
        CTRi[0] = 1'b0;
        push(0, 8'hFE, "glitch_c1");
        @(posedge INPCL); #1;
        push(0, 8'hFF, "glitch_passes");
        @(posedge INPCL); #1;
        push(0, 8'hFE, "glitch_gone");
        @(posedge INPCL); #1;
        RD0 = 1'b0;
`endif
        @(posedge INPCL); #1;
        CTRi[15:8] = 8'h5A;
        repeat (40) @(posedge INPCL);
        rd_both(3'd1, 8'h5A, "panel1_value");

        // Inter-CPU flags.
        wr(1'b1, 3'd2, 8'h01, 1'b0, 3'd0, 8'h00);
        rd_both(3'd2, 8'h06, "cpu0_set_flag0");
        wr(1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 8'h01);
        rd(0, 3'd2, 8'h02, "cpu1_clr_flag0");
        wr(1'b1, 3'd3, 8'hFF, 1'b1, 3'd5, 8'hFF);
        rd(0, 3'd2, 8'h02, "other_addr_ignored");
        wr(1'b1, 3'd2, 8'h02, 1'b1, 3'd2, 8'h02);
        rd(1, 3'd2, 8'h0A, "same_cycle_flag1_cpu1_sets");
        wr(1'b1, 3'd2, 8'h02, 1'b0, 3'd0, 8'h00);
        rd(0, 3'd2, 8'h02, "cpu0_clr_flag1");
        wr(1'b1, 3'd2, 8'h01, 1'b0, 3'd0, 8'h00);
        wr(1'b1, 3'd2, 8'h01, 1'b1, 3'd2, 8'h01);
        rd(0, 3'd2, 8'h02, "same_cycle_flag0_cpu1_clrs");
        wr(1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 8'h02);
        wr(1'b1, 3'd2, 8'h03, 1'b0, 3'd0, 8'h00);
        rd(1, 3'd2, 8'h06, "cpu0_set0_clr1");

        // VBLK edge flags.
        @(posedge INPCL); #1;
        VBLK = 1'b1;
        repeat (4) @(posedge INPCL);
        rd(0, 3'd2, 8'h04, "vblk_high_status");
        rd(0, 3'd3, 8'h03, "vbe_both_set");
        rd(1, 3'd3, 8'h02, "vbe0_cleared");
        rd(0, 3'd3, 8'h00, "vbe1_cleared");
        @(posedge INPCL); #1;
        VBLK = 1'b0;
        repeat (4) @(posedge INPCL);
        // Rise reaches the edge detector two clocks after VBLK; RD1 lands then.
        @(posedge INPCL); #1;
        VBLK = 1'b1;
        @(posedge INPCL); #1;
        @(posedge INPCL); #1;
        AD1 = 3'd3; RD1 = 1'b1;
        push(1, 8'h00, "pre_coincide");
        @(posedge INPCL); #1;
        RD1 = 1'b0;
        rd(0, 3'd3, 8'h03, "set_wins_over_clear");

        repeat (4) @(posedge INPCL);
        n_chk++;
        if (q0.size() == 0 && q1.size() == 0) n_pass++;
        else $display("FAIL pending_reads got %0d expected 0", q0.size() + q1.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
